// File: rtl/sieve_pkg.sv
// Shared constants and state encoding for the sieve engine and its bitmap consumers.
package sieve_pkg;

  localparam int N_MAX   = 100;
  localparam int VEC_W   = N_MAX + 1;
  localparam int IDX_W   = 7;
  localparam int COUNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } streamer_state_t;

endpackage

// File: rtl/prime_above_detect.sv
// Flags whether any bit of a bitmap is set strictly above a given index.
module prime_above_detect #(
  parameter int VEC_W = 101,
  parameter int IDX_W = 7
) (
  input  logic [VEC_W-1:0] mask_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             above_o
);

  // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
  always_comb begin
    above_o = 1'b0;
    for (int i = 0; i < VEC_W; i++) begin
      if (IDX_W'(i) > idx_i) above_o = above_o | mask_i[i];
    end
  end

endmodule

// File: rtl/prime_list_streamer.sv
// Latches the sieve's composite mask and streams the primes in ascending order
// over a valid/ready interface, marking the highest prime and counting accepted beats.
module prime_list_streamer
  import sieve_pkg::*;
#(
  parameter int N_MAX   = sieve_pkg::N_MAX,
  parameter int VEC_W   = N_MAX + 1,
  parameter int IDX_W   = sieve_pkg::IDX_W,
  parameter int COUNT_W = sieve_pkg::COUNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sieve_done,
  input  logic [VEC_W-1:0]   composite_mask,
  output logic               prime_valid,
  input  logic               prime_ready,
  output logic [IDX_W-1:0]   prime_value,
  output logic               prime_last,
  output logic [COUNT_W-1:0] prime_count,
  output logic               busy,
  output logic               stream_done
);

  streamer_state_t    state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]   value_q, value_d;
  logic               last_q, last_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;

  logic [VEC_W-1:0]   prime_mask;
  logic               any_above;

  // mask_q holds the composite view; the reset value of all ones means "no primes".
  assign prime_mask = ~mask_q;

  prime_above_detect #(
    .VEC_W (VEC_W),
    .IDX_W (IDX_W)
  ) u_above (
    .mask_i  (prime_mask),
    .idx_i   (idx_q),
    .above_o (any_above)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '1;
      value_q <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      last_q  <= last_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    value_d = value_q;
    last_d  = last_q;
    count_d = count_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (sieve_done) begin
          mask_d  = composite_mask;
          idx_d   = '0;
          count_d = '0;
          last_d  = 1'b0;
          done_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (prime_mask[idx_q]) begin
          value_d = idx_q;
          last_d  = ~any_above;
          state_d = EMIT;
        end else if (idx_q == IDX_W'(N_MAX)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      EMIT: begin
        if (prime_ready) begin
          if (count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        // A still-high sieve_done must not start a second run on the same mask.
        if (!sieve_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prime_valid = (state_q == EMIT);
  assign prime_value = value_q;
  assign prime_last  = last_q;
  assign prime_count = count_q;
  assign busy        = (state_q == SCAN) || (state_q == EMIT);
  assign stream_done = done_q;

endmodule

// File: tb/tb_prime_list_streamer.sv
// Self-checking bench for prime_list_streamer: expected prime lists come from a
// trial-division / bitmap-walk model, with randomized masks and backpressure.
module tb_prime_list_streamer;
  import sieve_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               sieve_done = 1'b0;
  logic [VEC_W-1:0]   composite_mask = '1;
  logic               prime_ready = 1'b0;
  logic               prime_valid;
  logic [IDX_W-1:0]   prime_value;
  logic               prime_last;
  logic [COUNT_W-1:0] prime_count;
  logic               busy;
  logic               stream_done;

  always #5 clock = ~clock;

  prime_list_streamer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sieve_done     (sieve_done),
    .composite_mask (composite_mask),
    .prime_valid    (prime_valid),
    .prime_ready    (prime_ready),
    .prime_value    (prime_value),
    .prime_last     (prime_last),
    .prime_count    (prime_count),
    .busy           (busy),
    .stream_done    (stream_done)
  );

  int n_total = 0;
  int n_pass  = 0;

  int exp_q[$];
  int beat_val[$];
  bit beat_last[$];
  int beat_cyc[$];
  int first_valid_cyc;
  int done_cyc;
  bit saw_last_any;
  logic [VEC_W-1:0] real_mask;

  function automatic logic [VEC_W-1:0] build_real_mask();
    logic [VEC_W-1:0] m;
    for (int i = 0; i <= N_MAX; i++) begin
      bit comp = (i < 2);
      for (int d = 2; d * d <= i; d++) if (i % d == 0) comp = 1'b1;
      m[i] = comp;
    end
    return m;
  endfunction

  function automatic logic [VEC_W-1:0] rand_mask();
    logic [VEC_W-1:0] m;
    for (int i = 0; i <= N_MAX; i++) m[i] = ($urandom_range(0, 3) != 0);
    m[0] = 1'b1;
    m[1] = 1'b1;
    return m;
  endfunction

  // Reference: primes are simply the clear bits of the mask, in ascending order.
  task automatic model_primes(input logic [VEC_W-1:0] m);
    exp_q.delete();
    for (int i = 0; i <= N_MAX; i++) if (!m[i]) exp_q.push_back(i);
  endtask

  // Runs one stream from the next rising edge (capture) until stream_done, recording beats.
  task automatic collect(input bit rand_ready, input bit disturb);
    bit pend = 1'b0;
    int pv = 0;
    bit pl = 1'b0;
    beat_val.delete();
    beat_last.delete();
    beat_cyc.delete();
    first_valid_cyc = -1;
    done_cyc = -1;
    saw_last_any = 1'b0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clock);
      if (pend) begin
        n_total++;
        if (prime_valid !== 1'b1 || int'(prime_value) != pv || prime_last !== pl)
          $display("FAIL hold_stable: got valid=%b value=%0d last=%b, want valid=1 value=%0d last=%b",
                   prime_valid, prime_value, prime_last, pv, pl);
        else n_pass++;
      end
      if (prime_last === 1'b1) saw_last_any = 1'b1;
      if (prime_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = c;
      if (stream_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (disturb && c == 2) begin
        sieve_done = 1'b0;
        composite_mask = rand_mask();
      end
      prime_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pend = (prime_valid === 1'b1) && !prime_ready;
      pv = int'(prime_value);
      pl = prime_last;
      if (prime_valid === 1'b1 && prime_ready) begin
        beat_val.push_back(int'(prime_value));
        beat_last.push_back(prime_last);
        beat_cyc.push_back(c);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_total++;
    if ({prime_valid, prime_last, busy, stream_done} !== 4'b0000)
      $display("FAIL reset_flags: got valid=%b last=%b busy=%b done=%b, want all 0",
               prime_valid, prime_last, busy, stream_done);
    else n_pass++;
    n_total++;
    if (prime_value !== '0 || prime_count !== '0)
      $display("FAIL reset_values: got value=%0d count=%0d, want 0/0", prime_value, prime_count);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    n_total++;
    if (busy !== 1'b0 || prime_valid !== 1'b0)
      $display("FAIL idle_no_start: got busy=%b valid=%b, want 0/0", busy, prime_valid);
    else n_pass++;
  endtask

  task automatic test_full_ready();
    composite_mask = real_mask;
    model_primes(real_mask);
    sieve_done = 1'b1;
    collect(1'b0, 1'b0);
    n_total++;
    if (beat_val.size() != 25) $display("FAIL full_beats: got %0d beats, want 25", beat_val.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < beat_val.size(); k++) begin
      n_total++;
      if (beat_val[k] != exp_q[k] || beat_last[k] != (k == exp_q.size() - 1))
        $display("FAIL full_beat%0d: got value=%0d last=%b, want value=%0d last=%b",
                 k, beat_val[k], beat_last[k], exp_q[k], (k == exp_q.size() - 1));
      else n_pass++;
    end
    n_total++;
    if (first_valid_cyc != 4) $display("FAIL latency: got first valid at cycle %0d, want 4", first_valid_cyc);
    else n_pass++;
    n_total++;
    if (beat_cyc.size() < 2 || beat_cyc[1] - beat_cyc[0] != 2)
      $display("FAIL back_to_back: got beat spacing %0d, want 2",
               beat_cyc.size() < 2 ? -1 : beat_cyc[1] - beat_cyc[0]);
    else n_pass++;
    n_total++;
    if (done_cyc < 0 || prime_count !== 7'd25 || busy !== 1'b0)
      $display("FAIL full_end: got done_cyc=%0d count=%0d busy=%b, want done, 25, 0",
               done_cyc, prime_count, busy);
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random_ready();
    composite_mask = real_mask;
    model_primes(real_mask);
    sieve_done = 1'b1;
    collect(1'b1, 1'b0);
    n_total++;
    if (beat_val != exp_q) $display("FAIL rand_sequence: got %0d beats, want %0d in order", beat_val.size(), exp_q.size());
    else n_pass++;
    n_total++;
    if (done_cyc < 0 || int'(prime_count) != exp_q.size())
      $display("FAIL rand_count: got done_cyc=%0d count=%0d, want done and %0d", done_cyc, prime_count, exp_q.size());
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_all_ones();
    composite_mask = '1;
    sieve_done = 1'b1;
    collect(1'b0, 1'b0);
    n_total++;
    if (beat_val.size() != 0 || first_valid_cyc != -1)
      $display("FAIL none_beats: got %0d beats (first valid %0d), want 0", beat_val.size(), first_valid_cyc);
    else n_pass++;
    n_total++;
    if (done_cyc != N_MAX + 2 || prime_count !== '0 || saw_last_any)
      $display("FAIL none_done: got done_cyc=%0d count=%0d last_seen=%b, want %0d 0 0",
               done_cyc, prime_count, saw_last_any, N_MAX + 2);
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_top_prime();
    logic [VEC_W-1:0] m;
    m = '1;
    m[N_MAX] = 1'b0;
    composite_mask = m;
    sieve_done = 1'b1;
    collect(1'b0, 1'b0);
    n_total++;
    if (beat_val.size() != 1 || beat_val[0] != N_MAX || beat_last[0] != 1'b1)
      $display("FAIL top_prime: got %0d beats first=%0d, want one beat %0d with last",
               beat_val.size(), beat_val.size() ? beat_val[0] : -1, N_MAX);
    else n_pass++;
    n_total++;
    if (first_valid_cyc != N_MAX + 2 || prime_count !== 7'd1)
      $display("FAIL top_prime_end: got first_valid=%0d count=%0d, want %0d 1", first_valid_cyc, prime_count, N_MAX + 2);
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_disturb();
    logic [VEC_W-1:0] m;
    m = rand_mask();
    model_primes(m);
    composite_mask = m;
    sieve_done = 1'b1;
    collect(1'b1, 1'b1);
    n_total++;
    if (beat_val != exp_q || int'(prime_count) != exp_q.size())
      $display("FAIL disturb: got %0d beats count=%0d, want %0d", beat_val.size(), prime_count, exp_q.size());
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_emit();
    bit hit = 1'b0;
    composite_mask = real_mask;
    model_primes(real_mask);
    sieve_done = 1'b1;
    prime_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (prime_valid === 1'b1 && prime_value === 7'd11) begin
        hit = 1'b1;
        break;
      end
    end
    n_total++;
    if (!hit) $display("FAIL reach_11: got no beat of 11, want one within 300 cycles");
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({prime_valid, prime_last, busy, stream_done} !== 4'b0000 || prime_value !== '0 || prime_count !== '0)
      $display("FAIL reset_abort: got valid=%b last=%b busy=%b done=%b value=%0d count=%0d, want all 0",
               prime_valid, prime_last, busy, stream_done, prime_value, prime_count);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    collect(1'b0, 1'b0);
    n_total++;
    if (beat_val != exp_q || prime_count !== 7'd25)
      $display("FAIL rerun: got %0d beats first=%0d count=%0d, want 25 from 2",
               beat_val.size(), beat_val.size() ? beat_val[0] : -1, prime_count);
    else n_pass++;
  endtask

  task automatic test_level_done();
    bit bad = 1'b0;
    logic [VEC_W-1:0] m;
    // sieve_done is still high from the previous run.
    repeat (20) begin
      @(negedge clock);
      if (prime_valid !== 1'b0 || busy !== 1'b0 || stream_done !== 1'b1) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL no_restart: got activity while sieve_done held high, want idle with done=1");
    else n_pass++;
    sieve_done = 1'b0;
    @(negedge clock);
    m = rand_mask();
    model_primes(m);
    composite_mask = m;
    sieve_done = 1'b1;
    collect(1'b1, 1'b0);
    n_total++;
    if (beat_val != exp_q || int'(prime_count) != exp_q.size() || done_cyc < 0)
      $display("FAIL new_run: got %0d beats count=%0d, want %0d", beat_val.size(), prime_count, exp_q.size());
    else n_pass++;
    sieve_done = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    real_mask = build_real_mask();
    test_reset();
    test_full_ready();
    test_random_ready();
    test_all_ones();
    test_top_prime();
    test_disturb();
    test_reset_mid_emit();
    test_level_done();
    for (int r = 0; r < 3; r++) test_disturb();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prime_list_streamer.md
Name: prime_list_streamer

Overview:
- Downstream consumer of the sieve engine.
- On `sieve_done`, latches the sieve's final composite mask, where bit i = 1 means i is NOT prime (bits 0 and 1 are always set by the sieve).
- Serialises the primes in ascending order over a valid/ready stream, flags the last prime and counts the primes emitted.
- Feeds the result logger / prime-check consumers that need indices rather than a bitmap.

Parameters:
- N_MAX, 100, largest integer covered by the mask.
- VEC_W, N_MAX+1, composite-mask width.
- IDX_W, 7, width of prime_value; must satisfy 2**IDX_W > N_MAX.
- COUNT_W, 7, width of prime_count; must hold the number of primes ≤ N_MAX.

Ports:
- clock, input, 1, system clock, rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- sieve_done, input, 1, level: the composite mask is final and stable.
- composite_mask, input, VEC_W, bit i = 1 means i is composite or 0/1; sampled only on capture.
- prime_valid, output, 1, prime_value is valid.
- prime_ready, input, 1, consumer accepts the beat.
- prime_value, output, IDX_W, current prime.
- prime_last, output, 1, current beat is the highest prime in the mask.
- prime_count, output, COUNT_W, primes accepted so far in this run.
- busy, output, 1, a run is in progress (SCAN or EMIT).
- stream_done, output, 1, run complete; prime_count is final.

Behaviour:
- Reset, asynchronous: state=IDLE, idx=0, latched mask=all 1s, prime_valid=0, prime_value=0, prime_last=0, prime_count=0, busy=0, stream_done=0.
- A reset mid-run aborts the run immediately. No partial beat survives reset.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - If sieve_done=1 at a rising edge: latch prime_mask = ~composite_mask, idx←0, prime_count←0, go to SCAN.
  - stream_done clears on entry to SCAN.
- SCAN (examines one index per cycle):
  - If prime_mask[idx]=1: prime_value←idx, prime_last←(no prime_mask bit set above idx), go to EMIT.
  - Else if idx==N_MAX: go to DONE.
  - Else: idx←idx+1.
- EMIT:
  - prime_valid=1. prime_value and prime_last are held stable until the handshake (prime_valid & prime_ready).
  - On handshake with prime_last=1: prime_count+1, go to DONE.
  - On handshake with prime_last=0: prime_count+1, idx←idx+1, go to SCAN.
  - No handshake: hold.
- DONE:
  - stream_done=1, prime_valid=0, prime_count frozen.
  - Returns to IDLE only when sieve_done=0. A level-high sieve_done never restarts a run.
- busy=1 in SCAN and EMIT only.
- Latency: a mask with first prime 2 has prime_valid high on the 4th cycle after the capture edge (SCAN idx 0, 1, 2, then EMIT).
- Boundaries:
  - prime_ready held high and back-to-back primes (2, 3): one SCAN cycle between beats.
  - All-ones mask (no primes): scans to N_MAX, enters DONE, prime_count=0, zero beats, prime_last never asserted.
  - Prime at N_MAX: emitted with prime_last=1. idx never exceeds N_MAX.
  - sieve_done deasserting mid-run: ignored; the latched mask is used.
  - composite_mask changes after capture: ignored.
  - prime_ready asserted while prime_valid=0: ignored.
- Widths: prime_count saturates at 2**COUNT_W-1 (unreachable with defaults). idx compare is unsigned.

Decomposition:
- Shared package (sieve_pkg):
  - N_MAX, VEC_W, IDX_W, COUNT_W constants.
  - streamer_state_t enum {IDLE, SCAN, EMIT, DONE}.
- One sub-module, prime_above_detect:
  - Combinational: OR of mask bits strictly above idx.
  - Produces prime_last.
  - Reusable by other bitmap consumers.

Test Plan:
- Real sieve mask for 0..100, prime_ready always 1 -> beats 2, 3, 5, …, 97 in order (25 beats), prime_last only on 97, prime_count=25, stream_done=1.
- Same mask, prime_ready toggled pseudo-randomly -> identical sequence; prime_value/prime_last stable while prime_valid=1 and prime_ready=0; no dropped or duplicated beat.
- composite_mask all 1s -> no prime_valid ever, stream_done after 101 SCAN cycles, prime_count=0.
- Mask with only bit 100 clear -> single beat prime_value=100 with prime_last=1, prime_count=1.
- reset_n pulsed low during EMIT of prime 11 -> outputs return to reset values at once. After release with sieve_done=1: fresh run from 2, prime_count restarts at 0.
- sieve_done held high through DONE -> no second run. Drop sieve_done 1 cycle then raise with a new mask -> new run streams the new mask.
